ocp_mem_arb: RTL and testbench
==============================

# ocp_mem_arb

Two-master to one-slave OCP arbiter that shares the behavioral RAM (or any single-outstanding OCP slave) between the CPU instruction-fetch port (master 0) and data port (master 1). It grants one transaction at a time using round-robin priority, forwards the granted command to the slave, and routes the slave response back to the owning master only. A watchdog returns an error response if the slave never answers.

## Interface
- TIMEOUT, 16: cycles to wait for a non-NULL slave response before the arbiter returns an error. 0 disables the watchdog.
- Bus widths `ADDR_WIDTH`, `DATA_WIDTH` and `BEN_WIDTH` come from common.vh. Command and response encodings come from ocp_const.vh (CMD IDLE/WRITE/READ; RESP NULL/DVA/ERR).

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- i_M0Addr / i_M1Addr  in  ADDR_WIDTH  master address
- i_M0Cmd / i_M1Cmd  in  3  master command
- i_M0Data / i_M1Data  in  DATA_WIDTH  master write data
- i_M0ByteEn / i_M1ByteEn  in  BEN_WIDTH  master byte enables
- o_M0SCmdAccept / o_M1SCmdAccept  out  1  command accept to master
- o_M0SData / o_M1SData  out  DATA_WIDTH  read data to master
- o_M0SResp / o_M1SResp  out  2  response to master
- o_MAddr, o_MCmd, o_MData, o_MByteEn  out  as above  command to slave
- i_SCmdAccept  in  1  slave accept
- i_SData  in  DATA_WIDTH  slave read data
- i_SResp  in  2  slave response

## Operation
- Request rule: master n requests when its MCmd is not IDLE. It holds Addr, Data, ByteEn and Cmd stable until its SCmdAccept=1 in the same cycle.
- FSM states: ARB, WAIT (one-hot encoding allowed).
- ARB state, selecting the grant:
  - If a lock is held, the locked master is granted.
  - Otherwise the requester is chosen by the priority pointer `prio`. `prio`=0 favours master 0; `prio`=1 favours master 1. A lone requester always wins.
- ARB state, forwarding:
  - The granted master's Addr, Cmd, Data and ByteEn are driven combinationally to the slave.
  - With no requester: o_MCmd=IDLE, and o_MAddr, o_MData and o_MByteEn are 0.
- ARB state, on acceptance (i_SCmdAccept=1 with a forwarded non-IDLE command):
  - Assert the granted master's SCmdAccept in the same cycle.
  - Register the grantee as `owner`, clear the lock, clear the timeout counter, and go to WAIT.
- ARB state, without acceptance: set the lock to the grantee. The grant must not switch masters until the forwarded command is accepted.
- WAIT state:
  - o_MCmd=IDLE.
  - Every cycle, a requesting master sees SCmdAccept=0.
  - When i_SResp≠NULL: drive the owner's SResp=i_SResp and SData=i_SData, set `prio` to the non-owner, and return to ARB next cycle.
  - Otherwise increment the counter. When the counter reaches TIMEOUT (and TIMEOUT≠0): drive the owner's SResp=ERR and SData=0, update `prio` the same way, and return to ARB.
- Non-owner / idle master outputs: SResp=NULL and SData=0 at all times.
- Idle master accept: SCmdAccept=1 whenever its own MCmd=IDLE, matching the slave convention.
- A slave response seen in ARB state is ignored; no master sees it.

## Timing
- Reset (asynchronous, nrst=0):
  - State ARB, `prio`=0, lock cleared, counter=0.
  - o_MCmd=IDLE; all other slave command outputs 0.
  - Both masters: SResp=NULL, SData=0, SCmdAccept=1 when MCmd=IDLE.
  - A reset during WAIT drops the outstanding transaction; no response is ever delivered for it.
- Latency: zero added cycles. The command passes through in its accept cycle, and the response passes through in its cycle.
  - Against the RAM: accept in cycle N, owner response in cycle N+1, ARB again in cycle N+2.
  - Back-to-back throughput is one transaction per 2 cycles.
- Simultaneous requests in ARB: the winner follows `prio`. After each completion, the loser is granted first.
- Counter width is ceil(log2(TIMEOUT+1)) bits; the counter saturates and does not wrap.

## Test plan
- Single read:
  - Stimulus: M0 READ at 0x10, while RAM word 4 = 0x11223344.
  - Response: o_M0SCmdAccept=1 in cycle N; o_M0SResp=DVA and o_M0SData=0x11223344 in cycle N+1; M1 outputs stay NULL/0.
- Contention:
  - Stimulus: M0 and M1 both assert READ from reset.
  - Response: M0 is served first; M1 is accepted in cycle N+2 and receives DVA in cycle N+3. Repeating the same stimulus alternates the winner.
- Byte write then read:
  - Stimulus: M1 WRITE 0xAABBCCDD with ByteEn=0101 to 0x20, where the word was previously 0; then M1 READ 0x20.
  - Response: the read returns 0x00BB00DD.
- Grant lock:
  - Stimulus: slave holds i_SCmdAccept=0 while M1 alone requests; M0 then raises its request.
  - Response: o_MAddr stays on M1's address until acceptance, and M1 is accepted first.
- Timeout:
  - Stimulus: stub slave accepts but never responds, with TIMEOUT=4.
  - Response: owner receives SResp=ERR and SData=0 exactly 4 cycles after WAIT entry; the arbiter then returns to ARB.
- Mid-transaction reset:
  - Stimulus: assert nrst=0 during WAIT.
  - Response: the FSM returns to ARB immediately, both SResp are NULL, and no late response is delivered after release.

Source files
------------

// File: rtl/ocp_mem_arb_if.sv
// One OCP link: master-side command signals and slave-side accept/response.
// The arbiter faces each CPU port with the slave modport and the memory with the master modport.
interface ocp_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEN_W  = 4
);
    logic [ADDR_W-1:0] MAddr;
    logic [2:0]        MCmd;
    logic [DATA_W-1:0] MData;
    logic [BEN_W-1:0]  MByteEn;
    logic              SCmdAccept;
    logic [DATA_W-1:0] SData;
    logic [1:0]        SResp;

    modport master (
        output MAddr, MCmd, MData, MByteEn,
        input  SCmdAccept, SData, SResp
    );

    modport slave (
        input  MAddr, MCmd, MData, MByteEn,
        output SCmdAccept, SData, SResp
    );
endinterface

// File: rtl/ocp_mem_arb.sv
// Round-robin arbiter sharing one single-outstanding OCP slave between the
// instruction-fetch port (m0) and the data port (m1), with a response watchdog.
module ocp_mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          nrst,
    ocp_mem_arb_if.slave  m0,
    ocp_mem_arb_if.slave  m1,
    ocp_mem_arb_if.master s
);

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_ARB  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic             prio, prio_nxt;
    logic             lock, lock_nxt;
    logic             lock_id, lock_id_nxt;
    logic             owner, owner_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic              req0, req1, any_req, grant;
    logic [ADDR_W-1:0] fwd_addr;
    logic [2:0]        fwd_cmd;
    logic [DATA_W-1:0] fwd_data;
    logic [BEN_W-1:0]  fwd_ben;
    logic [1:0]        rsp_code;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_vld;

    // Watchdog counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign req0    = (m0.MCmd != CMD_IDLE);
    assign req1    = (m1.MCmd != CMD_IDLE);
    assign any_req = req0 | req1;

    // A locked grantee keeps the grant only while it is still requesting.
    always_comb begin
        if (lock && (lock_id ? req1 : req0)) begin
            grant = lock_id;
        end else if (req0 && req1) begin
            grant = prio;
        end else begin
            grant = req1;
        end
    end

    always_comb begin
        fwd_addr = '0;
        fwd_cmd  = CMD_IDLE;
        fwd_data = '0;
        fwd_ben  = '0;
        if (state == ST_ARB && any_req) begin
            fwd_addr = grant ? m1.MAddr   : m0.MAddr;
            fwd_cmd  = grant ? m1.MCmd    : m0.MCmd;
            fwd_data = grant ? m1.MData   : m0.MData;
            fwd_ben  = grant ? m1.MByteEn : m0.MByteEn;
        end
    end

    assign s.MAddr   = fwd_addr;
    assign s.MCmd    = fwd_cmd;
    assign s.MData   = fwd_data;
    assign s.MByteEn = fwd_ben;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= ST_ARB;
            prio    <= 1'b0;
            lock    <= 1'b0;
            lock_id <= 1'b0;
            owner   <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            prio    <= prio_nxt;
            lock    <= lock_nxt;
            lock_id <= lock_id_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        prio_nxt      = prio;
        lock_nxt      = lock;
        lock_id_nxt   = lock_id;
        owner_nxt     = owner;
        cnt_nxt       = cnt;
        rsp_vld       = 1'b0;
        rsp_code      = RESP_NULL;
        rsp_data      = '0;
        m0.SCmdAccept = ~req0;
        m1.SCmdAccept = ~req1;
        unique case (state)
            ST_ARB: begin
                if (any_req) begin
                    if (s.SCmdAccept) begin
                        if (grant) begin
                            m1.SCmdAccept = 1'b1;
                        end else begin
                            m0.SCmdAccept = 1'b1;
                        end
                        owner_nxt = grant;
                        lock_nxt  = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = ST_WAIT;
                    end else begin
                        lock_nxt    = 1'b1;
                        lock_id_nxt = grant;
                    end
                end
            end
            ST_WAIT: begin
                if (s.SResp != RESP_NULL) begin
                    rsp_vld   = 1'b1;
                    rsp_code  = s.SResp;
                    rsp_data  = s.SData;
                    prio_nxt  = ~owner;
                    state_nxt = ST_ARB;
                end else if (WDOG_EN && cnt == CNT_LIMIT) begin
                    rsp_vld   = 1'b1;
                    rsp_code  = RESP_ERR;
                    prio_nxt  = ~owner;
                    state_nxt = ST_ARB;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            default: begin
                state_nxt = ST_ARB;
            end
        endcase
    end

    // Only the owner of the outstanding transaction ever sees a response.
    always_comb begin
        m0.SResp = RESP_NULL;
        m0.SData = '0;
        m1.SResp = RESP_NULL;
        m1.SData = '0;
        if (rsp_vld) begin
            if (owner) begin
                m1.SResp = rsp_code;
                m1.SData = rsp_data;
            end else begin
                m0.SResp = rsp_code;
                m0.SData = rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_ocp_mem_arb.sv
// Bench for ocp_mem_arb: behavioural RAM slave, scoreboard of expected responses,
// a transaction table and hand-written contention/lock/timeout/reset sequences.
module tb_ocp_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 4;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_WRITE = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    typedef struct {
        logic        m;
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
        logic [1:0]  eresp;
        logic [31:0] edata;
    } vec_t;

    typedef struct {
        logic        m;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    logic [31:0] mem [0:63];
    logic        mem_clr;
    logic        slv_acc_en;
    logic        slv_resp_en;
    logic        pend;
    logic [31:0] pend_data;

    ocp_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW), .BEN_W(BW)) m0_if ();
    ocp_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW), .BEN_W(BW)) m1_if ();
    ocp_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW), .BEN_W(BW)) s_if ();

    ocp_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .BEN_W(BW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .nrst (nrst),
        .m0   (m0_if),
        .m1   (m1_if),
        .s    (s_if)
    );

    always #5 clk = ~clk;

    // RAM slave: answers one cycle after accept; a response held back by
    // slv_resp_en stays pending until it is finally delivered or replaced.
    function automatic logic [31:0] ben_mask(input logic [3:0] b);
        return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    assign s_if.SCmdAccept = slv_acc_en;
    assign s_if.SResp      = (pend && slv_resp_en) ? RESP_DVA : RESP_NULL;
    assign s_if.SData      = (pend && slv_resp_en) ? pend_data : 32'h0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]    <= 32'h11223344;
            pend      <= 1'b0;
            pend_data <= 32'h0;
        end else if (slv_acc_en && s_if.MCmd != CMD_IDLE) begin
            pend <= 1'b1;
            if (s_if.MCmd == CMD_READ) begin
                pend_data <= mem[s_if.MAddr[7:2]];
            end else begin
                mem[s_if.MAddr[7:2]] <= (mem[s_if.MAddr[7:2]] & ~ben_mask(s_if.MByteEn))
                                      | (s_if.MData & ben_mask(s_if.MByteEn));
                pend_data <= 32'h0;
            end
        end else if (pend && slv_resp_en) begin
            pend <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic got(input logic m, input logic [1:0] r, input logic [31:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: master %0d got resp %0d data %h, expected no response (t=%0t)",
                     m, r, d, $time);
        end else begin
            e = sb.pop_front();
            check("sb_master", 32'(m), 32'(e.m));
            check("sb_resp", 32'(r), 32'(e.resp));
            check("sb_data", d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (m0_if.SResp !== RESP_NULL) got(1'b0, m0_if.SResp, m0_if.SData);
        if (m1_if.SResp !== RESP_NULL) got(1'b1, m1_if.SResp, m1_if.SData);
    end

    task automatic drive(input logic m, input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] ben);
        if (m) begin
            m1_if.MCmd = cmd; m1_if.MAddr = addr; m1_if.MData = data; m1_if.MByteEn = ben;
        end else begin
            m0_if.MCmd = cmd; m0_if.MAddr = addr; m0_if.MData = data; m0_if.MByteEn = ben;
        end
    endtask

    task automatic push(input logic m, input logic [1:0] r, input logic [31:0] d);
        exp_t e;
        e.m = m; e.resp = r; e.data = d;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic acc_of(input logic m);
        return m ? m1_if.SCmdAccept : m0_if.SCmdAccept;
    endfunction

    function automatic logic [1:0] resp_of(input logic m);
        return m ? m1_if.SResp : m0_if.SResp;
    endfunction

    // Returns at the falling edge of the accept cycle.
    task automatic wait_accept(input logic m, input string name);
        logic acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = acc_of(m);
            if (!acc) next_cycle();
        end
        check(name, 32'(acc), 32'd1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && sb.size() != 0; k++) next_cycle();
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic run_txn(input vec_t v);
        drive(v.m, v.cmd, v.addr, v.data, v.ben);
        wait_accept(v.m, "vec_accept");
        push(v.m, v.eresp, v.edata);
        next_cycle();
        drive(v.m, CMD_IDLE, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "tb_ocp_mem_arb timed out");
    end

    initial begin
        vec_t vecs[8];
        logic exp_w;

        mem_clr     = 1'b1;
        slv_acc_en  = 1'b1;
        slv_resp_en = 1'b1;
        drive(1'b0, CMD_IDLE, 32'h0, 32'h0, 4'h0);
        drive(1'b1, CMD_IDLE, 32'h0, 32'h0, 4'h0);

        vecs[0] = '{1'b0, CMD_READ,  32'h10, 32'h0,        4'hF, RESP_DVA, 32'h11223344};
        vecs[1] = '{1'b1, CMD_WRITE, 32'h20, 32'hAABBCCDD, 4'h5, RESP_DVA, 32'h0};
        vecs[2] = '{1'b1, CMD_READ,  32'h20, 32'h0,        4'hF, RESP_DVA, 32'h00BB00DD};
        vecs[3] = '{1'b0, CMD_WRITE, 32'h30, 32'hDEADBEEF, 4'hF, RESP_DVA, 32'h0};
        vecs[4] = '{1'b0, CMD_READ,  32'h30, 32'h0,        4'hF, RESP_DVA, 32'hDEADBEEF};
        vecs[5] = '{1'b1, CMD_WRITE, 32'h30, 32'h12345678, 4'hA, RESP_DVA, 32'h0};
        vecs[6] = '{1'b0, CMD_READ,  32'h30, 32'h0,        4'hF, RESP_DVA, 32'h12AD56EF};
        vecs[7] = '{1'b1, CMD_READ,  32'h10, 32'h0,        4'hF, RESP_DVA, 32'h11223344};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mcmd",   32'(s_if.MCmd),          32'(CMD_IDLE));
        check("rst_maddr",  s_if.MAddr,              32'h0);
        check("rst_mdata",  s_if.MData,              32'h0);
        check("rst_mben",   32'(s_if.MByteEn),       32'h0);
        check("rst_m0resp", 32'(m0_if.SResp),        32'(RESP_NULL));
        check("rst_m0data", m0_if.SData,             32'h0);
        check("rst_m0acc",  32'(m0_if.SCmdAccept),   32'd1);
        check("rst_m1resp", 32'(m1_if.SResp),        32'(RESP_NULL));
        check("rst_m1data", m1_if.SData,             32'h0);
        check("rst_m1acc",  32'(m1_if.SCmdAccept),   32'd1);
        next_cycle();
        nrst    = 1'b1;
        mem_clr = 1'b0;

        // Both masters request continuously from reset: winners alternate, one accept every 2 cycles.
        drive(1'b0, CMD_READ, 32'h10, 32'h0, 4'hF);
        drive(1'b1, CMD_READ, 32'h20, 32'h0, 4'hF);
        exp_w = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cont_acc_win",  32'(acc_of(exp_w)),  32'd1);
            check("cont_acc_lose", 32'(acc_of(~exp_w)), 32'd0);
            check("cont_addr",     s_if.MAddr, exp_w ? 32'h20 : 32'h10);
            push(exp_w, RESP_DVA, exp_w ? 32'h0 : 32'h11223344);
            next_cycle();
            @(negedge clk);
            check("cont_wait_acc", 32'({m0_if.SCmdAccept, m1_if.SCmdAccept}), 32'd0);
            check("cont_wait_cmd", 32'(s_if.MCmd), 32'(CMD_IDLE));
            check("cont_resp",     32'(resp_of(exp_w)),  32'(RESP_DVA));
            check("cont_resp_lose", 32'(resp_of(~exp_w)), 32'(RESP_NULL));
            next_cycle();
            exp_w = ~exp_w;
        end
        drive(1'b0, CMD_IDLE, 32'h0, 32'h0, 4'h0);
        drive(1'b1, CMD_IDLE, 32'h0, 32'h0, 4'h0);
        drain("cont_drain");

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);
        drain("vec_drain");

        // Grant lock: M1 is forwarded while the slave stalls; M0 must not steal the grant.
        slv_acc_en = 1'b0;
        drive(1'b1, CMD_READ, 32'h20, 32'h0, 4'hF);
        @(negedge clk);
        check("lock_addr0", s_if.MAddr, 32'h20);
        check("lock_m1_acc0", 32'(acc_of(1'b1)), 32'd0);
        next_cycle();
        drive(1'b0, CMD_READ, 32'h10, 32'h0, 4'hF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("lock_addr", s_if.MAddr, 32'h20);
            check("lock_m0_acc", 32'(acc_of(1'b0)), 32'd0);
            next_cycle();
        end
        slv_acc_en = 1'b1;
        @(negedge clk);
        check("lock_m1_acc", 32'(acc_of(1'b1)), 32'd1);
        check("lock_m0_hold", 32'(acc_of(1'b0)), 32'd0);
        push(1'b1, RESP_DVA, 32'h00BB00DD);
        next_cycle();
        drive(1'b1, CMD_IDLE, 32'h0, 32'h0, 4'h0);
        wait_accept(1'b0, "lock_m0_later");
        push(1'b0, RESP_DVA, 32'h11223344);
        next_cycle();
        drive(1'b0, CMD_IDLE, 32'h0, 32'h0, 4'h0);
        drain("lock_drain");

        // Watchdog: slave accepts but stays silent; ERR comes 4 cycles after WAIT entry.
        slv_resp_en = 1'b0;
        drive(1'b0, CMD_READ, 32'h10, 32'h0, 4'hF);
        wait_accept(1'b0, "to_acc");
        push(1'b0, RESP_ERR, 32'h0);
        next_cycle();
        drive(1'b0, CMD_IDLE, 32'h0, 32'h0, 4'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("to_quiet", 32'(m0_if.SResp), 32'(RESP_NULL));
            next_cycle();
        end
        @(negedge clk);
        check("to_err",  32'(m0_if.SResp), 32'(RESP_ERR));
        check("to_data", m0_if.SData, 32'h0);
        check("to_m1",   32'(m1_if.SResp), 32'(RESP_NULL));
        next_cycle();
        slv_resp_en = 1'b1;
        drive(1'b1, CMD_READ, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        check("to_arb_acc", 32'(acc_of(1'b1)), 32'd1);
        push(1'b1, RESP_DVA, 32'h11223344);
        next_cycle();
        drive(1'b1, CMD_IDLE, 32'h0, 32'h0, 4'h0);
        drain("to_drain");

        // Reset during WAIT: the outstanding read is dropped, its late response ignored.
        slv_resp_en = 1'b0;
        drive(1'b0, CMD_READ, 32'h30, 32'h0, 4'hF);
        wait_accept(1'b0, "mrst_acc");
        next_cycle();
        drive(1'b0, CMD_IDLE, 32'h0, 32'h0, 4'h0);
        nrst = 1'b0;
        @(negedge clk);
        check("mrst_m0resp", 32'(m0_if.SResp), 32'(RESP_NULL));
        check("mrst_m1resp", 32'(m1_if.SResp), 32'(RESP_NULL));
        check("mrst_mcmd",   32'(s_if.MCmd),   32'(CMD_IDLE));
        check("mrst_m0acc",  32'(acc_of(1'b0)), 32'd1);
        next_cycle();
        next_cycle();
        nrst        = 1'b1;
        slv_resp_en = 1'b1;
        drive(1'b1, CMD_READ, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        check("mrst_arb_acc", 32'(acc_of(1'b1)), 32'd1);
        check("mrst_late",    32'(m0_if.SResp), 32'(RESP_NULL));
        push(1'b1, RESP_DVA, 32'h11223344);
        next_cycle();
        drive(1'b1, CMD_IDLE, 32'h0, 32'h0, 4'h0);
        repeat (4) next_cycle();
        drain("mrst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
